st_to_mm_fifo_bridge: RTL
=========================

# st_to_mm_fifo_bridge

Parametrised Avalon-ST sink to Avalon-MM read/write slave bridge with an internal single-clock FIFO. It stores each accepted beat together with its sideband (sop, eop, empty, channel, error) in one memory entry, so data and sideband always pop together. It adds a fill-level and status register, a programmable almost-full threshold and an optional drop-on-full mode. It sits between a streaming producer and the HPS/Nios memory-mapped interconnect.

## Interface
- DATA_W, 32: stream data width, 8..32; readdata is zero-extended.
- DEPTH, 32: FIFO entries; power of two, 4..1024.
- CHANNEL_W, 8: channel width.
- ERROR_W, 8: error width.
- EMPTY_W, 2: empty-symbol width. Constraint: ERROR_W+CHANNEL_W+EMPTY_W+2 <= 32.
- DROP_MODE, 0: 0 = backpressure, 1 = sink always ready and beats are dropped when full.
- AF_DEFAULT, DEPTH-4: reset value of the almost-full threshold.
- LVL_W (derived): $clog2(DEPTH)+1.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- avalonst_sink_data/valid/sop/eop/empty/channel/error  in  DATA_W/1/1/1/EMPTY_W/CHANNEL_W/ERROR_W  stream beat.
- avalonst_sink_ready  out  1  beat accepted when valid & ready.
- avalonmm_slave_address  in  2  register select.
- avalonmm_slave_read / write  in  1  access strobes.
- avalonmm_slave_writedata  in  32.
- avalonmm_slave_readdata  out  32  registered.
- avalonmm_slave_waitrequest  out  1.
- almost_full  out  1  level >= threshold; registered.

## Operation
- Push = sink_valid & sink_ready. Pop = read & address==0 & !waitrequest.
- sink_ready:
  - DROP_MODE=0: !reset & (level != DEPTH).
  - DROP_MODE=1: !reset.
- Drop mode: a valid beat arriving while level==DEPTH is discarded, and drop_cnt (8 bits) increments, saturating at 255.
- Full is judged on the level at the start of the cycle. A push while full is rejected or dropped even if a pop occurs in the same cycle.
- waitrequest = read & address==0 & empty. A data read stalls until a beat exists, so underflow cannot occur. All other addresses never wait.
- Register map:
  - Address 0 DATA, read-only, pops: readdata = {0, data}. The popped beat's sideband is latched into info_q.
  - Address 1 INFO, read-only: {0, error, channel, empty, eop, sop} of the last popped beat. Reading it has no side effect.
  - Address 2 STATUS, read: [LVL_W-1:0] level, [16] empty, [17] full, [18] almost_full, [31:24] drop_cnt. Any write clears drop_cnt.
  - Address 3 THRESH, read/write: almost-full threshold [LVL_W-1:0]; upper bits read as 0.
- Level update: push & pop together leaves level unchanged. Pointers wrap modulo DEPTH.
- A write to addresses 0 or 1 is ignored. A drop and a STATUS write in the same cycle clear drop_cnt; the clear wins.
- Reset (any time, including mid-stall): FIFO flushed, level 0, info_q 0, drop_cnt 0, threshold AF_DEFAULT, readdata 0, almost_full 0, sink_ready 0.

## Timing
- Read latency is fixed at 1. readdata updates on the cycle after an accepted read, and holds its value otherwise.
- Push to poppable: a beat pushed in cycle N makes empty deassert in N+1. A stalled DATA read completes in N+1 and its readdata appears in N+2.
- almost_full and STATUS reflect the level after the previous edge.
- A threshold write takes effect on almost_full one cycle later.

## Structure
- Package st_mm_bridge_pkg holds:
  - register address constants;
  - STATUS bit positions;
  - the function that packs sideband into the INFO word.
- Sub-module sync_fifo_mem (WIDTH, DEPTH) provides the memory, pointers, level, and empty/full flags, with a registered read port. Entry width is DATA_W+ERROR_W+CHANNEL_W+EMPTY_W+2.
- The top level contains the handshake, the register decode, drop_cnt and the threshold register.

## Test plan
- Reset, then push 3 beats 0x11/0x22/0x33 (channel 5, error 0). Three DATA reads return 0x11, 0x22, 0x33 in order, and STATUS level goes 3→0.
- DATA read on an empty FIFO → waitrequest high for 4 cycles. Push 0xAB → the read completes and readdata=0xAB on the following cycle. INFO then returns channel/error of that beat.
- DROP_MODE=0, fill DEPTH beats → sink_ready=0 and full=1. Pop and push in the same cycle → the push is not accepted, and level becomes DEPTH-1.
- DROP_MODE=1, push DEPTH+300 beats without reads → level=DEPTH and drop_cnt=255. A STATUS write → drop_cnt=0.
- Write THRESH=2, push 2 beats → almost_full rises one cycle after the second push. Pop 1 → almost_full falls.
- Assert reset with 5 beats stored and a read stalled → all outputs at reset values, and the first read after release stalls (empty).

Source files
------------

// File: rtl/st_mm_bridge_pkg.sv
// Shared constants and helpers for the streaming-to-memory-mapped FIFO bridge.
package st_mm_bridge_pkg;

   // Register map
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_INFO   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_THRESH = 2'd3;

   // STATUS word bit positions (level occupies the low bits)
   localparam int unsigned ST_EMPTY_BIT = 16;
   localparam int unsigned ST_FULL_BIT  = 17;
   localparam int unsigned ST_AF_BIT    = 18;
   localparam int unsigned ST_DROP_LSB  = 24;
   localparam int unsigned DROP_CNT_W   = 8;

   // Packs a beat's sideband into the INFO word: {0, error, channel, empty, eop, sop}
   function automatic logic [31:0] pack_info(
      input logic [31:0] i_error,
      input logic [31:0] i_channel,
      input logic [31:0] i_empty,
      input logic        i_eop,
      input logic        i_sop,
      input int unsigned i_channel_w,
      input int unsigned i_empty_w
   );
      pack_info = (i_error   << (i_channel_w + i_empty_w + 2)) |
                  (i_channel << (i_empty_w + 2)) |
                  (i_empty   << 2) |
                  {30'd0, i_eop, i_sop};
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO storage with wrapping pointers, fill level, flags and a
// registered read port that holds the most recently popped entry.
module sync_fifo_mem #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [$clog2(DEPTH):0]   o_level_nxt_c,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_nxt;
   logic             r_empty;
   logic             r_full;
   logic [WIDTH-1:0] r_rdata;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & ~r_empty;

   // Next fill level; simultaneous push and pop cancel out
   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - LVL_W'(1);
      end
   end

   // Pointers, level, flags and the popped-entry register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_rdata  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_rdata  <= r_mem[r_rd_ptr];
         end
         r_level <= w_level_nxt;
         r_empty <= (w_level_nxt == '0);
         r_full  <= (w_level_nxt == LVL_W'(DEPTH));
      end
   end

   // Storage array; contents need no reset since the pointers define validity
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_rdata       = r_rdata;
   assign o_level       = r_level;
   assign o_level_nxt_c = w_level_nxt;
   assign o_empty       = r_empty;
   assign o_full        = r_full;

endmodule

// File: rtl/st_to_mm_fifo_bridge.sv
// Avalon-ST sink to Avalon-MM slave bridge: beats and their sideband are queued
// together and drained through a small register map with status and thresholds.
module st_to_mm_fifo_bridge
   import st_mm_bridge_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned CHANNEL_W  = 8,
   parameter int unsigned ERROR_W    = 8,
   parameter int unsigned EMPTY_W    = 2,
   parameter int unsigned DROP_MODE  = 0,
   parameter int unsigned AF_DEFAULT = DEPTH - 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     avalonst_sink_data,
   input  logic                  avalonst_sink_valid,
   input  logic                  avalonst_sink_sop,
   input  logic                  avalonst_sink_eop,
   input  logic [EMPTY_W-1:0]    avalonst_sink_empty,
   input  logic [CHANNEL_W-1:0]  avalonst_sink_channel,
   input  logic [ERROR_W-1:0]    avalonst_sink_error,
   output logic                  avalonst_sink_ready,
   input  logic [1:0]            avalonmm_slave_address,
   input  logic                  avalonmm_slave_read,
   input  logic                  avalonmm_slave_write,
   input  logic [31:0]           avalonmm_slave_writedata,
   output logic [31:0]           avalonmm_slave_readdata,
   output logic                  avalonmm_slave_waitrequest,
   output logic                  almost_full
);

   localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
   localparam int unsigned SB_W    = ERROR_W + CHANNEL_W + EMPTY_W + 2;
   localparam int unsigned ENTRY_W = DATA_W + SB_W;
   localparam int unsigned EMP_LSB = DATA_W + 2;
   localparam int unsigned CH_LSB  = EMP_LSB + EMPTY_W;
   localparam int unsigned ERR_LSB = CH_LSB + CHANNEL_W;

   logic [ENTRY_W-1:0]    w_wdata;
   logic [ENTRY_W-1:0]    w_last_entry;
   logic [LVL_W-1:0]      w_level;
   logic [LVL_W-1:0]      w_level_nxt;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_drop;
   logic                  w_rd_data;
   logic                  w_rd_accept;
   logic                  w_wr_status;
   logic                  w_wr_thresh;
   logic [LVL_W-1:0]      w_thresh_nxt;
   logic [31:0]           w_info;
   logic [31:0]           w_status;
   logic                  w_unused;

   logic [LVL_W-1:0]      r_thresh;
   logic [DROP_CNT_W-1:0] r_drop_cnt;
   logic                  r_af;
   logic                  r_sel_data;
   logic [31:0]           r_rdata_reg;

   // Stream handshake; fullness is judged on the level at the start of the cycle
   assign avalonst_sink_ready = (DROP_MODE != 0) ? ~reset : (~reset & ~w_full);
   assign w_push = avalonst_sink_valid & avalonst_sink_ready & ~w_full;
   assign w_drop = avalonst_sink_valid & w_full & (DROP_MODE != 0);

   // Memory-mapped access decode
   assign w_rd_data   = avalonmm_slave_read & (avalonmm_slave_address == ADDR_DATA);
   assign avalonmm_slave_waitrequest = w_rd_data & w_empty;
   assign w_pop       = w_rd_data & ~w_empty;
   assign w_rd_accept = avalonmm_slave_read & ~avalonmm_slave_waitrequest;
   assign w_wr_status = avalonmm_slave_write & (avalonmm_slave_address == ADDR_STATUS);
   assign w_wr_thresh = avalonmm_slave_write & (avalonmm_slave_address == ADDR_THRESH);
   assign w_unused    = ^avalonmm_slave_writedata[31:LVL_W];

   assign w_wdata = {avalonst_sink_error, avalonst_sink_channel, avalonst_sink_empty,
                     avalonst_sink_eop, avalonst_sink_sop, avalonst_sink_data};

   sync_fifo_mem #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk         (clock),
      .i_rst         (reset),
      .i_push        (w_push),
      .i_wdata       (w_wdata),
      .i_pop         (w_pop),
      .o_rdata       (w_last_entry),
      .o_level       (w_level),
      .o_level_nxt_c (w_level_nxt),
      .o_empty       (w_empty),
      .o_full        (w_full)
   );

   // The FIFO read register doubles as info_q: it holds the last popped beat
   assign w_info = pack_info(32'(w_last_entry[ERR_LSB +: ERROR_W]),
                             32'(w_last_entry[CH_LSB +: CHANNEL_W]),
                             32'(w_last_entry[EMP_LSB +: EMPTY_W]),
                             w_last_entry[DATA_W + 1],
                             w_last_entry[DATA_W],
                             CHANNEL_W, EMPTY_W);

   // STATUS word assembly from current registered state
   always_comb begin
      w_status                                   = '0;
      w_status[LVL_W-1:0]                        = w_level;
      w_status[ST_EMPTY_BIT]                     = w_empty;
      w_status[ST_FULL_BIT]                      = w_full;
      w_status[ST_AF_BIT]                        = r_af;
      w_status[ST_DROP_LSB +: DROP_CNT_W]        = r_drop_cnt;
   end

   // Threshold value after this edge, so writes reach almost_full one cycle later
   always_comb begin
      w_thresh_nxt = r_thresh;
      if (w_wr_thresh) begin
         w_thresh_nxt = avalonmm_slave_writedata[LVL_W-1:0];
      end
   end

   // Threshold, almost-full flag and drop counter (a STATUS write clear beats a drop)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_thresh   <= LVL_W'(AF_DEFAULT);
         r_af       <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_thresh <= w_thresh_nxt;
         r_af     <= (w_level_nxt >= w_thresh_nxt);
         if (w_wr_status) begin
            r_drop_cnt <= '0;
         end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
         end
      end
   end

   // Read-data capture; DATA reads select the FIFO's own read register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sel_data  <= 1'b0;
         r_rdata_reg <= '0;
      end else if (w_rd_accept) begin
         r_sel_data <= (avalonmm_slave_address == ADDR_DATA);
         unique case (avalonmm_slave_address)
            ADDR_INFO:   r_rdata_reg <= w_info;
            ADDR_STATUS: r_rdata_reg <= w_status;
            ADDR_THRESH: r_rdata_reg <= 32'(r_thresh);
            default:     r_rdata_reg <= r_rdata_reg;
         endcase
      end
   end

   assign avalonmm_slave_readdata = r_sel_data ? 32'(w_last_entry[DATA_W-1:0]) : r_rdata_reg;
   assign almost_full             = r_af;

endmodule
